// File: rtl/ceil_div_arbiter.sv
// ceil_div_arbiter: round-robin arbiter sharing one radix-2 restoring ceiling divider
module ceil_div_arbiter #(
  parameter int NumReq = 4,
  parameter int Width = 32,
  parameter int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0][Width-1:0]  dividend_i,
  input  logic [NumReq-1:0][Width-1:0]  divisor_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [Width-1:0]              rsp_quotient_o,
  output logic [IdxW-1:0]               rsp_id_o,
  output logic                          rsp_div_zero_o
);
  localparam int CntW = $clog2(Width);
  localparam logic [NumReq-1:0] One = 1;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;
  state_e state, state_nxt;
  logic [IdxW-1:0] ptr, win, id;
  logic any, dz, accept, last, ge;
  int k;
  logic [Width-1:0] dvd, dvs, q;
  logic [Width:0] rem, rem_sh;
  logic [CntW-1:0] cnt;
  always_comb begin
    win = '0;
    any = 1'b0;
    k = 0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NumReq;
      if (req_valid_i[k]) begin
        win = IdxW'(k);
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any ? (divisor_i[win] == '0 ? DONE : DIV) : IDLE;
      DIV:     state_nxt = last ? DONE : DIV;
      DONE:    state_nxt = rsp_ready_i ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    accept = state == IDLE && any;
    req_ready_o = (accept && rst_ni) ? One << win : '0;
    rsp_valid_o = state == DONE;
    rsp_quotient_o = dz ? '1 : q + {{(Width-1){1'b0}}, |rem};
    rsp_id_o = id;
    rsp_div_zero_o = dz;
  end
  assign last = cnt == CntW'(Width - 1);
  assign rem_sh = {rem[Width-1:0], dvd[Width-1]};
  assign ge = rem_sh >= {1'b0, dvs};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
      id <= '0;
      dz <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      q <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (accept) begin
      id <= win;
      dz <= divisor_i[win] == '0;
      dvd <= dividend_i[win];
      dvs <= divisor_i[win];
      q <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (state == DIV) begin
      dvd <= dvd << 1;
      q <= {q[Width-2:0], ge};
      rem <= ge ? rem_sh - {1'b0, dvs} : rem_sh;
      cnt <= cnt + CntW'(1);
    end else if (state == DONE && rsp_ready_i) begin
      ptr <= id == IdxW'(NumReq - 1) ? '0 : id + IdxW'(1);
    end
  end
endmodule
